// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline-stage registers: stage-bundle widths,
// occupancy encoding and the bubble value a stage register holds after reset.
package cpu_pipe_pkg;

    localparam int IF_ID_W     = 64;   // pc + fetched instruction
    localparam int ID_EX_W     = 148;
    localparam int EX_MEM_W    = 106;
    localparam int MEM_WB_W    = 71;
    localparam int MAX_STAGE_W = 148;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'd1;
    localparam logic [1:0] OCC_SKID  = 2'd2;

    // The control state doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY   = OCC_EMPTY,
        ST_FULL    = OCC_FULL,
        ST_SKIDDED = OCC_SKID
    } occ_state_e;

    // An all-zero bundle decodes as a NOP with every write-enable cleared.
    localparam logic [MAX_STAGE_W-1:0] NOP_BUNDLE = '0;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload register with load enable; used for the main and skid
// entries of a pipeline stage.
module pipe_data_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // NOTE: the payload is reset as well, so downstream sees the defined bubble rather than X out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RESET_VAL;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, flush, occupancy and
// an optional two-entry skid buffer that registers in_ready.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(NOP_BUNDLE),
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy
);

    occ_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             in_fire, out_fire;
    logic             load_main, main_from_skid;
    logic [WIDTH-1:0] skid_data, main_d;

    // Without the skid entry the stage can only refill in the cycle it drains.
    assign in_ready = SKID ? in_ready_q : (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // NOTE: every signal this block drives gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d   = ST_FULL;
                    load_main = 1'b1;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    state_d = SKID ? ST_SKIDDED : ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKIDDED: begin
                if (out_fire) begin
                    state_d        = ST_FULL;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d   = ST_EMPTY;
            load_main = 1'b0;
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_SKIDDED);
    end

    // NOTE: state registers use <= so every flop samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign main_d = main_from_skid ? skid_data : in_data;

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_main),
        .d_i    (main_d),
        .q_o    (out_data)
    );

    if (SKID) begin : g_skid
        logic load_skid;

        // The skid entry captures exactly the beat that arrived while main was stalled.
        assign load_skid = (state_q == ST_FULL) && (state_d == ST_SKIDDED);

        pipe_data_reg #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_skid (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (load_skid),
            .d_i    (in_data),
            .q_o    (skid_data)
        );
    end else begin : g_no_skid
        assign skid_data = RESET_VAL;
    end

    assign out_valid = out_valid_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one instance with the skid buffer, one without.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;

    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0), .SKID(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .flush(a_flush), .occupancy(a_occ)
    );

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0), .SKID(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .flush(b_flush), .occupancy(b_occ)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs are applied just after a rising edge; the scoreboard is updated at the
    // falling edge, and the task returns just after the edge that consumed them.
    task automatic a_drive(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
        a_in_valid = v; a_in_data = d; a_out_ready = ordy; a_flush = fl;
        @(negedge clk);
        if (fl) exp_a.delete();
        else if (v && a_in_ready) exp_a.push_back(d);
        @(posedge clk); #1;
    endtask

    task automatic b_drive(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
        b_in_valid = v; b_in_data = d; b_out_ready = ordy; b_flush = fl;
        @(negedge clk);
        if (fl) exp_b.delete();
        else if (v && b_in_ready) exp_b.push_back(d);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_spurious_out: got %h, expected no output", a_out_data);
            end else begin
                check("a_out_data", a_out_data, exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_spurious_out: got %h, expected no output", b_out_data);
            end else begin
                check("b_out_data", b_out_data, exp_b.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'hDEADBEEF; a_out_ready = 1'b1; a_flush = 1'b0;
        b_in_valid = 1'b1; b_in_data = 32'hDEADBEEF; b_out_ready = 1'b1; b_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("a_rst_out_valid", 32'(a_out_valid), 32'd0);
        check("a_rst_out_data",  a_out_data,       32'h0);
        check("a_rst_in_ready",  32'(a_in_ready),  32'd1);
        check("a_rst_occ",       32'(a_occ),       32'd0);
        check("b_rst_out_valid", 32'(b_out_valid), 32'd0);
        check("b_rst_in_ready",  32'(b_in_ready),  32'd1);
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First transfer after reset, then back-to-back streaming.
        a_drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        check("a_first_valid", 32'(a_out_valid), 32'd1);
        check("a_first_data",  a_out_data,       32'hDEADBEEF);
        for (int k = 1; k <= 4; k++) begin
            a_drive(1'b1, 32'(k), 1'b1, 1'b0);
            check("a_stream_data", a_out_data, 32'(k));
            check("a_stream_occ",  32'(a_occ), 32'd1);
        end
        a_drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("a_drain_occ", 32'(a_occ), 32'd0);

        // Backpressure fills the skid entry.
        a_drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        check("a_bp_occ1",   32'(a_occ),      32'd1);
        check("a_bp_ready1", 32'(a_in_ready), 32'd1);
        a_drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
        check("a_bp_occ2",   32'(a_occ),      32'd2);
        check("a_bp_ready2", 32'(a_in_ready), 32'd0);
        check("a_bp_head",   a_out_data,      32'hAAAA_0001);
        a_drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("a_bp_stable", a_out_data,       32'hAAAA_0001);
        check("a_bp_valid",  32'(a_out_valid), 32'd1);
        a_drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("a_bp_next",   a_out_data,      32'hBBBB_0002);
        check("a_bp_occ3",   32'(a_occ),      32'd1);
        check("a_bp_ready3", 32'(a_in_ready), 32'd1);
        a_drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("a_bp_empty", 32'(a_occ), 32'd0);

        // Flush from SKIDDED and from FULL with a live input.
        a_drive(1'b1, 32'hA2A2_A2A2, 1'b0, 1'b0);
        a_drive(1'b1, 32'hB2B2_B2B2, 1'b0, 1'b0);
        check("a_fl_pre_occ", 32'(a_occ), 32'd2);
        a_drive(1'b1, 32'hCCCC_CCCC, 1'b0, 1'b1);
        check("a_fl_valid", 32'(a_out_valid), 32'd0);
        check("a_fl_occ",   32'(a_occ),       32'd0);
        check("a_fl_ready", 32'(a_in_ready),  32'd1);
        a_drive(1'b1, 32'h1111_1111, 1'b0, 1'b0);
        a_drive(1'b1, 32'h2222_2222, 1'b0, 1'b1);
        check("a_fl2_valid", 32'(a_out_valid), 32'd0);
        check("a_fl2_occ",   32'(a_occ),       32'd0);
        a_drive(1'b1, 32'hDDDD_DDDD, 1'b1, 1'b0);
        check("a_fl_next", a_out_data, 32'hDDDD_DDDD);
        a_drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle while FULL.
        a_drive(1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0);
        check("a_ar_pre_valid", 32'(a_out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_a.delete();
        #1;
        check("a_ar_valid", 32'(a_out_valid), 32'd0);
        check("a_ar_data",  a_out_data,       32'h0);
        check("a_ar_occ",   32'(a_occ),       32'd0);
        check("a_ar_ready", 32'(a_in_ready),  32'd1);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        a_drive(1'b1, 32'hF00D_F00D, 1'b1, 1'b0);
        check("a_ar_after", a_out_data, 32'hF00D_F00D);
        a_drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Single-entry stage: combinational in_ready under backpressure.
        b_drive(1'b1, 32'hA0A0_0000, 1'b0, 1'b0);
        check("b_bp_valid", 32'(b_out_valid), 32'd1);
        check("b_bp_head",  b_out_data,       32'hA0A0_0000);
        check("b_bp_occ",   32'(b_occ),       32'd1);
        check("b_bp_ready", 32'(b_in_ready),  32'd0);
        b_drive(1'b1, 32'hB0B0_0000, 1'b0, 1'b0);
        check("b_bp_stable", b_out_data,      32'hA0A0_0000);
        check("b_bp_occ2",   32'(b_occ),      32'd1);
        b_out_ready = 1'b1;
        #1;
        check("b_comb_ready", 32'(b_in_ready), 32'd1);
        b_drive(1'b1, 32'hB0B0_0000, 1'b1, 1'b0);
        check("b_order_next", b_out_data, 32'hB0B0_0000);
        check("b_order_occ",  32'(b_occ), 32'd1);
        for (int k = 5; k <= 7; k++) begin
            b_drive(1'b1, 32'(k), 1'b1, 1'b0);
            check("b_stream_data", b_out_data, 32'(k));
        end
        b_drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("b_drain_occ", 32'(b_occ), 32'd0);
        b_drive(1'b1, 32'h6666_6666, 1'b0, 1'b0);
        b_drive(1'b1, 32'h7777_7777, 1'b0, 1'b1);
        check("b_fl_valid", 32'(b_out_valid), 32'd0);
        check("b_fl_ready", 32'(b_in_ready),  32'd1);
        b_drive(1'b0, 32'h0, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        check("a_sb_drained", 32'(exp_a.size()), 32'd0);
        check("b_sb_drained", 32'(exp_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline-stage register for the CPU datapath; the next generation of the plain always-load stage register.
- Adds valid/ready handshake, backpressure (stall), flush, an optional 2-entry skid buffer and an occupancy indication.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), carrying a packed stage bundle of WIDTH bits.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- RESET_VAL, 0, value of out_data after reset; WIDTH bits.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has data.
- in_ready  out  1  stage can accept; a transfer happens when in_valid && in_ready at a clk edge.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage holds data for downstream.
- out_ready  in  1  downstream accepts; out fire = out_valid && out_ready.
- out_data  out  WIDTH  payload at head of stage.
- flush  in  1  synchronous kill of all held entries (branch/exception).
- occupancy  out  2  number of held entries (0..2; never 2 when SKID=0).

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, occupancy=0, out_data=RESET_VAL, skid entry invalid, in_ready=1. All outputs are driven from registers except in_ready when SKID=0.
- Latency: data accepted at edge N appears on out_data with out_valid=1 after edge N. Throughput: 1 transfer/cycle sustained when out_ready=1.
- Ordering: strict FIFO; no entry is dropped or duplicated except by flush.
- SKID=1 state machine (state = occupancy):
  - EMPTY (0): in_ready=1. in fire -> FULL, main<=in_data.
  - FULL (1): in_ready=1. in fire and out fire -> FULL, main<=in_data. In fire only -> SKIDDED, skid<=in_data. Out fire only -> EMPTY. Neither -> hold.
  - SKIDDED (2): in_ready=0. Out fire -> FULL, main<=skid. Otherwise hold. in_valid is ignored.
  - in_ready is a registered signal equal to (state != SKIDDED), so no combinational path runs from out_ready to in_ready.
- SKID=0: in_ready = !out_valid || out_ready (combinational). States are EMPTY/FULL only. In fire loads main. Out fire without in fire -> EMPTY.
- Stall: while out_ready=0, out_data and out_valid are held stable. Once out_valid=1, it does not drop without an out fire or flush.
- Flush: at the edge where flush=1, next state is EMPTY, out_valid=0 and occupancy=0, regardless of in fire or out fire that cycle. An input presented in the flush cycle is discarded. in_ready=1 on the following cycle. out_data keeps its last value (don't-care while invalid). Flush has priority over every other transition.
- Reset mid-operation: immediately returns to the reset state; held entries are lost.
- out_data is only updated on a main load, so downstream sees no glitches while it is stalled.

Decomposition:
- Shared package cpu_pipe_pkg: stage-bundle widths (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W), the occupancy encoding constants OCC_EMPTY=0/OCC_FULL=1/OCC_SKID=2, and the default RESET_VAL bubble (NOP bundle).
- One natural sub-module: pipe_data_reg (WIDTH-bit register with asynchronous active-low reset to RESET_VAL and load enable), instantiated for the main and skid entries.
- Control FSM stays in pipe_stage_reg.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, out_data=RESET_VAL(0), in_ready=1, occupancy=0. Deassert rst_n -> first in fire yields out_data=DEADBEEF one cycle later.
- Streaming: out_ready=1, send 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on consecutive cycles, each one cycle after its accept; occupancy stays ≤1.
- Backpressure (SKID=1): out_ready=0, send A then B -> occupancy 1 then 2, in_ready=0 after B, out_data=A stable. Raise out_ready -> A, then B delivered; in_ready returns to 1 one cycle after the first out fire.
- Backpressure (SKID=0): out_ready=0 after accepting A -> in_ready=0 combinationally; B is held upstream and not lost; order A,B is preserved.
- Flush: state SKIDDED (A,B held), assert flush together with in_valid=1, in_data=C -> next cycle out_valid=0, occupancy=0, C not delivered. Send D -> D is the next output.
- Asynchronous reset in the FULL state mid-cycle (not on a clk edge) -> out_valid falls immediately and out_data=RESET_VAL before the next edge.
